// File: rtl/crc_pkg.sv
// Shared state encoding and default CRC constants for the serial CRC generator.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    SHIFT_IN  = 2'b01,
    SHIFT_OUT = 2'b10
  } state_e;

  localparam int          DEF_CRC_WIDTH = 8;
  localparam logic [31:0] DEF_POLY      = 32'h0000_0007;
  localparam logic [31:0] DEF_SEED      = 32'h0000_0000;

endpackage

// File: rtl/crc_lfsr.sv
// CRC register: seed load, serial Galois-style update, and right-shift unload.
module crc_lfsr #(
  parameter int                   CRC_WIDTH = 8,
  parameter logic [CRC_WIDTH-1:0] POLY      = '0,
  parameter logic [CRC_WIDTH-1:0] SEED      = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_seed_i,
  input  logic                 shift_in_i,
  input  logic                 data_i,
  input  logic                 shift_out_i,
  output logic [CRC_WIDTH-1:0] crc_o
);

  logic [CRC_WIDTH-1:0] crc_q, crc_d;
  logic                 fb;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    crc_d = crc_q;
    fb    = data_i ^ crc_q[CRC_WIDTH-1];
    if (load_seed_i) begin
      crc_d = SEED;
    end else if (shift_in_i) begin
      crc_d = {crc_q[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    end else if (shift_out_i) begin
      crc_d = {1'b0, crc_q[CRC_WIDTH-1:1]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments; combinational logic above uses blocking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_q <= SEED;
    else     crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/crc_serial_gen.sv
// Serial CRC generator: absorbs a framed bit stream, then emits the CRC bit 0 first.
// Define CRC_CHECK_EN to add the zero-residue checker outputs Check_Ok / Check_Valid.
module crc_serial_gen
  import crc_pkg::*;
#(
  parameter int                   CRC_WIDTH = DEF_CRC_WIDTH,
  parameter logic [CRC_WIDTH-1:0] POLY      = CRC_WIDTH'(DEF_POLY),
  parameter logic [CRC_WIDTH-1:0] SEED      = CRC_WIDTH'(DEF_SEED)
) (
  input  logic CLK,
  input  logic RST,
  input  logic Data,
  input  logic Active,
  output logic valid,
  output logic CRC,
  output logic Busy
`ifdef CRC_CHECK_EN
  ,
  output logic Check_Ok,
  output logic Check_Valid
`endif
);

  localparam int CNT_W = $clog2(CRC_WIDTH);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 load_seed, shift_in, shift_out;
  logic [CRC_WIDTH-1:0] crc_reg;

  crc_lfsr #(
    .CRC_WIDTH (CRC_WIDTH),
    .POLY      (POLY),
    .SEED      (SEED)
  ) u_lfsr (
    .clk         (CLK),
    .rst         (RST),
    .load_seed_i (load_seed),
    .shift_in_i  (shift_in),
    .data_i      (Data),
    .shift_out_i (shift_out),
    .crc_o       (crc_reg)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_seed = 1'b0;
    shift_in  = 1'b0;
    shift_out = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Active) begin
          state_d  = SHIFT_IN;
          shift_in = 1'b1;
        end
      end
      SHIFT_IN: begin
        if (Active) begin
          shift_in = 1'b1;
        end else begin
          state_d = SHIFT_OUT;
          cnt_d   = CNT_W'(CRC_WIDTH - 1);
        end
      end
      SHIFT_OUT: begin
        // Active is deliberately ignored here; only the counter ends the unload.
        if (cnt_q == '0) begin
          state_d   = IDLE;
          load_seed = 1'b1;
        end else begin
          shift_out = 1'b1;
          cnt_d     = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        load_seed = 1'b1;
        cnt_d     = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid = (state_q == SHIFT_OUT);
  assign Busy  = valid;
  assign CRC   = valid & crc_reg[0];

`ifdef CRC_CHECK_EN
  logic check_ok_q, check_valid_q;

  // Register at end of frame holds the residue; zero means message plus appended CRC is intact.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      check_ok_q    <= 1'b0;
      check_valid_q <= 1'b0;
    end else begin
      check_valid_q <= (state_q == SHIFT_IN) && !Active;
      check_ok_q    <= (state_q == SHIFT_IN) && !Active && (crc_reg == '0);
    end
  end

  assign Check_Ok    = check_ok_q;
  assign Check_Valid = check_valid_q;
`endif

endmodule

// File: doc/crc_serial_gen.md
CRC_SERIAL_GEN -- requirements
Module: crc_serial_gen

Interface
REQ-001 The block SHALL have a parameter CRC_WIDTH, default 8, giving the CRC register width in bits (legal range 4..32).
REQ-002 The block SHALL have a parameter POLY, default 'h07, giving the generator polynomial without the implicit x^CRC_WIDTH term.
REQ-003 The block SHALL have a parameter SEED, default 'h00, giving the register value loaded at reset and at the start of every frame.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port Data, input, 1 bit: serial message bit, LSB of each byte first, sampled while Active=1.
REQ-007 The block SHALL have port Active, input, 1 bit: frame enable, high for every message bit.
REQ-008 The block SHALL have port valid, output, 1 bit: high while CRC carries result bits.
REQ-009 The block SHALL have port CRC, output, 1 bit: serial CRC result, bit 0 first.
REQ-010 The block SHALL have port Busy, output, 1 bit: high in SHIFT_OUT; Active is ignored while Busy=1.

Function
REQ-011 The block SHALL implement three states: IDLE, SHIFT_IN and SHIFT_OUT.
REQ-012 IDLE SHALL go to SHIFT_IN on a CLK edge with Active=1, absorbing that edge's Data bit.
REQ-013 In SHIFT_IN, each CLK edge with Active=1 SHALL update the register: fb = Data ^ reg[CRC_WIDTH-1]; reg = (reg << 1) ^ (fb ? POLY : 0).
REQ-014 In SHIFT_IN, the first edge with Active=0 SHALL enter SHIFT_OUT without updating the register and load the bit counter with CRC_WIDTH-1.
REQ-015 In SHIFT_OUT, valid SHALL be 1 and CRC SHALL equal reg[0].
REQ-016 Each SHIFT_OUT edge SHALL shift the register right with zero fill and decrement the counter.
REQ-017 The edge with the counter at 0 SHALL return the FSM to IDLE, reload SEED and drop valid, giving exactly CRC_WIDTH valid cycles.
REQ-018 Latency from the falling Active edge to the first valid bit SHALL be exactly one CLK cycle.
REQ-019 In IDLE, valid=0, CRC=0 and Busy=0.
REQ-020 Active=1 during SHIFT_OUT SHALL be ignored; the first frame bit is the first edge with Active=1 after the return to IDLE.
REQ-021 Back-to-back frames SHALL work with zero idle gap after valid falls.
REQ-022 A frame of arbitrary length of at least 1 bit SHALL be supported; no internal length limit applies.

Reset
REQ-023 Asserting RST SHALL immediately force the FSM to IDLE, the register to SEED, the counter to 0 and valid, CRC and Busy to 0, including mid-frame and mid-output.
REQ-024 After RST deasserts, the first edge with Active=1 SHALL start a new frame.

Configuration
REQ-025 With macro CRC_CHECK_EN defined, the block SHALL add output ports Check_Ok and Check_Valid (1 bit each).
REQ-026 With CRC_CHECK_EN defined, on the SHIFT_IN->SHIFT_OUT edge Check_Valid SHALL pulse high for one cycle with Check_Ok = (register == 0), i.e. the received frame including its appended CRC has a zero residue.
REQ-027 With CRC_CHECK_EN defined, Check_Ok and Check_Valid SHALL reset to 0.
REQ-028 Without CRC_CHECK_EN, neither port nor its logic SHALL exist, and the behaviour SHALL be otherwise identical.

Structure
REQ-029 Package crc_pkg SHALL hold the state encoding (IDLE=2'b00, SHIFT_IN=2'b01, SHIFT_OUT=2'b10) and the default POLY/SEED constants.
REQ-030 Sub-module crc_lfsr SHALL contain the register and its update/shift logic, with the FSM and counter in crc_serial_gen.

Verification
REQ-031 Defaults, Data byte 0x80 (bits 0,0,0,0,0,0,0,1), then Active low -> valid high 8 cycles, CRC bits 1,1,1,0,0,0,0,0, reassembled 0x07.
REQ-032 Defaults, Data byte 0xFF -> reassembled result 0xF3; valid goes low after exactly 8 cycles.
REQ-033 Defaults, Data byte 0x00 -> result 0x00; a second frame 0x80 with zero gap -> 0x07, with no carry-over from the first frame.
REQ-034 RST pulsed after 4 data bits, then a full 0x80 frame -> result 0x07; valid stays 0 throughout the aborted frame.
REQ-035 Active held high during SHIFT_OUT -> output sequence unchanged, Busy=1, and the ignored bits do not affect the next frame.
REQ-036 With CRC_CHECK_EN, 16-bit frame 0x80 then 0xE0 -> Check_Valid pulse with Check_Ok=1; frame 0x80 then 0xE1 -> Check_Ok=0.
